// File: rtl/timer_pkg.sv
// Shared types and defaults for the programmable countdown / one-shot timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam int TIMER_WIDTH_DEFAULT = 32;

endpackage : timer_pkg

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer; master = CPU control path, slave = timer.
interface countdown_timer_if
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH_DEFAULT
) ();

    logic             enable;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             ack;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             expired;
    logic             done_pulse;

    modport master (
        output enable, load, data, ack,
        input  out_data, busy, expired, done_pulse
    );

    modport slave (
        input  enable, load, data, ack,
        output out_data, busy, expired, done_pulse
    );

endinterface : countdown_timer_if

// File: rtl/countdown_timer.sv
// Loadable down-counter that flags expiry (or reloads periodically when AUTO_RELOAD_EN is defined).
// Latency: load visible after one edge; all outputs registered; no backpressure, load/ack are strobes.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  tif
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    timer_state_t     r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_busy;
    logic             r_expired;
    logic             r_pulse;

    timer_state_t     w_state_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_pulse_nxt;

`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_reload;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reload <= '0;
        end else if (tif.load) begin
            r_reload <= tif.data;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_expired <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= (w_state_nxt == RUN);
            r_expired <= (w_state_nxt == DONE);
            r_pulse   <= w_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = 1'b0;

        // A load always wins, whatever state we are in; a zero load expires at once.
        if (tif.load) begin
            if (tif.data != '0) begin
                w_cnt_nxt   = tif.data;
                w_state_nxt = RUN;
            end else begin
                w_cnt_nxt   = '0;
                w_state_nxt = DONE;
                w_pulse_nxt = 1'b1;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                RUN: begin
                    if (tif.enable) begin
                        // Count saturates at zero rather than wrapping.
                        if (r_cnt <= CNT_ONE) begin
                            w_pulse_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
                            w_cnt_nxt   = r_reload;
                            w_state_nxt = RUN;
`else
                            w_cnt_nxt   = '0;
                            w_state_nxt = DONE;
`endif
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_ONE;
                        end
                    end
                end
                DONE: begin
                    w_cnt_nxt = '0;
                    if (tif.ack) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign tif.out_data   = r_cnt;
    assign tif.busy       = r_busy;
    assign tif.expired    = r_expired;
    assign tif.done_pulse = r_pulse;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: inputs change 1ns after a rising edge, outputs checked there too.
module tb_countdown_timer;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    countdown_timer_if #(.WIDTH(32)) tif ();

    countdown_timer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .tif   (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] cnt, input logic b,
                           input logic e, input logic p);
        chk({tag, ".out_data"},   tif.out_data,   cnt);
        chk({tag, ".busy"},       tif.busy,       {31'd0, b});
        chk({tag, ".expired"},    tif.expired,    {31'd0, e});
        chk({tag, ".done_pulse"}, tif.done_pulse, {31'd0, p});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b0;
        tif.enable = 1'b0;
        tif.load   = 1'b0;
        tif.data   = '0;
        tif.ack    = 1'b0;

        #2;
        chk_all("reset", 32'd0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        step();
        chk_all("idle_after_reset", 32'd0, 1'b0, 1'b0, 1'b0);

`ifndef AUTO_RELOAD_EN
        // Load 3 and count to zero.
        tif.load = 1'b1; tif.data = 32'd3; tif.enable = 1'b1;
        step();
        tif.load = 1'b0;
        chk_all("ld3_c3", 32'd3, 1'b1, 1'b0, 1'b0);
        step(); chk_all("ld3_c2", 32'd2, 1'b1, 1'b0, 1'b0);
        step(); chk_all("ld3_c1", 32'd1, 1'b1, 1'b0, 1'b0);
        step(); chk_all("ld3_c0", 32'd0, 1'b0, 1'b1, 1'b1);
        step(); chk_all("ld3_sticky", 32'd0, 1'b0, 1'b1, 1'b0);

        // Ack releases DONE back to IDLE.
        tif.ack = 1'b1;
        step();
        tif.ack = 1'b0;
        chk_all("ack_idle", 32'd0, 1'b0, 1'b0, 1'b0);
        step(); chk_all("idle_hold", 32'd0, 1'b0, 1'b0, 1'b0);

        // Load 5, pause after two decrements, then resume.
        tif.load = 1'b1; tif.data = 32'd5;
        step();
        tif.load = 1'b0;
        chk_all("ld5_c5", 32'd5, 1'b1, 1'b0, 1'b0);
        step(); chk("ld5_c4", tif.out_data, 32'd4);
        step(); chk("ld5_c3", tif.out_data, 32'd3);
        tif.enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all("ld5_hold", 32'd3, 1'b1, 1'b0, 1'b0);
        end
        tif.enable = 1'b1;
        step(); chk("ld5_resume_c2", tif.out_data, 32'd2);
        step(); chk("ld5_resume_c1", tif.out_data, 32'd1);

        // Reload on the cycle that would have been the final decrement.
        tif.load = 1'b1; tif.data = 32'd9;
        step();
        tif.load = 1'b0;
        chk_all("reload_beats_zero", 32'd9, 1'b1, 1'b0, 1'b0);

        // Reach DONE, then load and ack together: load wins.
        tif.load = 1'b1; tif.data = 32'd1;
        step();
        tif.load = 1'b0;
        chk("ld1_c1", tif.out_data, 32'd1);
        tif.ack = 1'b1;
        step();
        chk_all("ack_in_run_ignored", 32'd0, 1'b0, 1'b1, 1'b1);
        tif.load = 1'b1; tif.data = 32'd6;
        step();
        tif.load = 1'b0; tif.ack = 1'b0;
        chk_all("done_load_ack", 32'd6, 1'b1, 1'b0, 1'b0);

        // Load of zero while running expires immediately.
        tif.load = 1'b1; tif.data = 32'd0;
        step();
        tif.load = 1'b0;
        chk_all("ld0_run", 32'd0, 1'b0, 1'b1, 1'b1);
        tif.ack = 1'b1;
        step();
        tif.ack = 1'b0;
        chk_all("ack2_idle", 32'd0, 1'b0, 1'b0, 1'b0);

        // Load of zero from IDLE.
        tif.load = 1'b1; tif.data = 32'd0;
        step();
        tif.load = 1'b0;
        chk_all("ld0_idle", 32'd0, 1'b0, 1'b1, 1'b1);

        // Full-scale start value decrements by one (unsigned arithmetic).
        tif.load = 1'b1; tif.data = 32'hFFFF_FFFF;
        step();
        tif.load = 1'b0;
        chk_all("ldmax", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        step(); chk("ldmax_dec", tif.out_data, 32'hFFFF_FFFE);

        // Asynchronous reset in the middle of a count.
        tif.load = 1'b1; tif.data = 32'd7; tif.enable = 1'b0;
        step();
        tif.load = 1'b0;
        chk_all("ld7", 32'd7, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_reset", 32'd0, 1'b0, 1'b0, 1'b0);
        tif.enable = 1'b1;
        step();
        reset = 1'b1;
        step();
        chk_all("post_reset_idle", 32'd0, 1'b0, 1'b0, 1'b0);
`else
        // Periodic mode: done_pulse every 4 cycles, never expires.
        tif.load = 1'b1; tif.data = 32'd4; tif.enable = 1'b1;
        step();
        tif.load = 1'b0;
        chk_all("ar_c4", 32'd4, 1'b1, 1'b0, 1'b0);
        for (int p = 0; p < 3; p++) begin
            step(); chk_all("ar_c3", 32'd3, 1'b1, 1'b0, 1'b0);
            step(); chk_all("ar_c2", 32'd2, 1'b1, 1'b0, 1'b0);
            step(); chk_all("ar_c1", 32'd1, 1'b1, 1'b0, 1'b0);
            step(); chk_all("ar_wrap", 32'd4, 1'b1, 1'b0, 1'b1);
        end
        tif.load = 1'b1; tif.data = 32'd0;
        step();
        tif.load = 1'b0;
        chk_all("ar_ld0", 32'd0, 1'b0, 1'b1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_all("ar_async_reset", 32'd0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_countdown_timer
